// File: rtl/pipe_regfile_sb_pkg.sv
// Shared constants for the scoreboarded pipeline register file.
package pipe_regfile_sb_pkg;

   localparam int DATA_W_DEF = 32;  // default register data width
   localparam int CNT_W_DEF  = 2;   // default pending-write counter width
   localparam int NUM_REGS   = 32;  // architectural register count
   localparam int IDX_W      = 5;   // register index width

endpackage

// File: rtl/pipe_sb_counter.sv
// Single pending-write counter: saturating up/down with a clear that
// overrides any same-cycle increment or decrement.
module pipe_sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   // Next count: simultaneous inc and dec cancel; both directions saturate.
   always_comb begin
      count_next = count_reg;
      if (inc && !dec && count_reg != CNT_MAX)
         count_next = count_reg + CNT_W'(1);
      else if (dec && !inc && count_reg != '0)
         count_next = count_reg - CNT_W'(1);
   end

   // Count register; reset and flush both clear it.
   always_ff @(posedge clk) begin
      if (rst || flush)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

   assign count = count_reg;

endmodule

// File: rtl/pipe_regfile_sb.sv
// 32-entry register file with writeback bypass and a per-register
// pending-write scoreboard that stalls issue on RAW hazards and on
// destination-counter overflow.
module pipe_regfile_sb
   import pipe_regfile_sb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rs_addr,
   input  logic [IDX_W-1:0]  rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              issue_valid,
   input  logic              issue_wr,
   input  logic [IDX_W-1:0]  issue_dest,
   output logic              stall,
   input  logic              wb_valid,
   input  logic [IDX_W-1:0]  wb_dest,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] regs_reg [NUM_REGS];
   logic [CNT_W-1:0]  cnt      [NUM_REGS];

   logic wb_write;
   logic accept;
   logic rs_pend;
   logic rt_pend;
   logic dest_full;

   assign wb_write = wb_valid && (wb_dest != '0);

   // Register storage; register 0 is never written and always reads 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_reg[i] <= '0;
      end else if (wb_write) begin
         regs_reg[wb_dest] <= wb_data;
      end
   end

   // Read ports: writeback data bypasses storage for a matching nonzero index.
   always_comb begin
      rs_data = regs_reg[rs_addr];
      rt_data = regs_reg[rt_addr];
      if (rs_addr == '0)
         rs_data = '0;
      else if (wb_valid && wb_dest == rs_addr)
         rs_data = wb_data;
      if (rt_addr == '0)
         rt_data = '0;
      else if (wb_valid && wb_dest == rt_addr)
         rt_data = wb_data;
   end

   // A source stops being pending in the cycle its last outstanding write
   // arrives, since the bypass already supplies the value.
   assign rs_pend = (cnt[rs_addr] != '0) &&
                    !(wb_valid && wb_dest == rs_addr && cnt[rs_addr] == CNT_ONE);
   assign rt_pend = (cnt[rt_addr] != '0) &&
                    !(wb_valid && wb_dest == rt_addr && cnt[rt_addr] == CNT_ONE);
   // A writeback in the same cycle does not relieve a full destination counter.
   assign dest_full = issue_wr && (cnt[issue_dest] == CNT_MAX);

   assign stall  = issue_valid && (rs_pend || rt_pend || dest_full);
   assign accept = issue_valid && !stall;

   // Register 0 never carries pending writes.
   assign cnt[0] = '0;

   generate
      for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
         logic inc;
         logic dec;
         assign inc = accept && issue_wr && (issue_dest == IDX_W'(gi));
         assign dec = wb_valid && (wb_dest == IDX_W'(gi));
         pipe_sb_counter #(
            .CNT_W (CNT_W)
         ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .inc   (inc),
            .dec   (dec),
            .count (cnt[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Directed-vector bench: stimulus pushes expected outputs into a queue,
// a monitor pops one entry per cycle and compares mid-cycle.
module tb_pipe_regfile_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs_addr, rt_addr, issue_dest, wb_dest;
   logic [31:0] rs_data, rt_data, wb_data;
   logic        issue_valid, issue_wr, stall, wb_valid, flush;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      string       name;
      bit          c_rs;
      logic [31:0] rs;
      bit          c_rt;
      logic [31:0] rt;
      bit          c_st;
      logic        st;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pipe_regfile_sb #(
      .DATA_W (32),
      .CNT_W  (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rs_addr     (rs_addr),
      .rt_addr     (rt_addr),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .issue_valid (issue_valid),
      .issue_wr    (issue_wr),
      .issue_dest  (issue_dest),
      .stall       (stall),
      .wb_valid    (wb_valid),
      .wb_dest     (wb_dest),
      .wb_data     (wb_data),
      .flush       (flush)
   );

   // Advance to just after the next rising edge.
   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                        input logic iv, input logic iw, input logic [4:0] idest,
                        input logic wv, input logic [4:0] wdest, input logic [31:0] wdata,
                        input logic fl, input logic r);
      rs_addr = rs; rt_addr = rt;
      issue_valid = iv; issue_wr = iw; issue_dest = idest;
      wb_valid = wv; wb_dest = wdest; wb_data = wdata;
      flush = fl; rst = r;
   endtask

   task automatic expect_out(input string n, input bit crs, input logic [31:0] ers,
                             input bit crt, input logic [31:0] ert,
                             input bit cst, input logic est);
      exp_t e;
      e.name = n; e.c_rs = crs; e.rs = ers; e.c_rt = crt; e.rt = ert;
      e.c_st = cst; e.st = est;
      sb.push_back(e);
   endtask

   // Monitor: one transaction per cycle, sampled at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("vec %-12s rs_data=%08h rt_data=%08h stall=%0b",
                     e.name, rs_data, rt_data, stall);
            if (e.c_rs) begin
               n_vec++;
               if (rs_data !== e.rs) begin
                  n_fail++;
                  $display("FAIL %s rs_data got=%08h want=%08h", e.name, rs_data, e.rs);
               end
            end
            if (e.c_rt) begin
               n_vec++;
               if (rt_data !== e.rt) begin
                  n_fail++;
                  $display("FAIL %s rt_data got=%08h want=%08h", e.name, rt_data, e.rt);
               end
            end
            if (e.c_st) begin
               n_vec++;
               if (stall !== e.st) begin
                  n_fail++;
                  $display("FAIL %s stall got=%0b want=%0b", e.name, stall, e.st);
               end
            end
         end
      end
   end

   initial begin
      int budget;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      go();
      go();
      // Reset state
      drive(5, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("reset", 1, 0, 1, 0, 1, 0);

      // Writeback bypass then storage
      go(); drive(5, 0, 1, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
      expect_out("wb_bypass", 1, 32'hDEADBEEF, 1, 0, 1, 0);
      go(); drive(5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("wb_stored", 1, 32'hDEADBEEF, 0, 0, 0, 0);

      // Writes to register 0 are dropped
      go(); drive(0, 5, 1, 0, 0, 1, 0, 32'h12345678, 0, 0);
      expect_out("r0_write", 1, 0, 1, 32'hDEADBEEF, 1, 0);
      go(); drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      expect_out("r0_after", 1, 0, 1, 0, 1, 0);

      // RAW on rs: pending 7, released by last writeback with bypass
      go(); drive(1, 2, 1, 1, 7, 0, 0, 0, 0, 0);
      expect_out("iss_w7", 0, 0, 0, 0, 1, 0);
      go(); drive(7, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("raw_rs7", 0, 0, 0, 0, 1, 1);
      go(); drive(7, 0, 1, 0, 0, 1, 7, 32'hA5A50007, 0, 0);
      expect_out("rel_rs7", 1, 32'hA5A50007, 0, 0, 1, 0);
      go(); drive(7, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("clr_rs7", 1, 32'hA5A50007, 0, 0, 1, 0);

      // RAW on rt; no stall while issue_valid is low
      go(); drive(0, 0, 1, 1, 7, 0, 0, 0, 0, 0);
      expect_out("iss_w7b", 0, 0, 0, 0, 1, 0);
      go(); drive(0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("noval_rt7", 0, 0, 0, 0, 1, 0);
      go(); drive(0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("raw_rt7", 0, 0, 1, 32'hA5A50007, 1, 1);
      go(); drive(0, 7, 0, 0, 0, 1, 7, 32'h00000077, 0, 0);
      expect_out("wb_rt7", 0, 0, 1, 32'h00000077, 0, 0);

      // Destination counter saturation on register 9
      go(); drive(0, 0, 1, 1, 9, 0, 0, 0, 0, 0);
      expect_out("w9_1", 0, 0, 0, 0, 1, 0);
      go(); drive(0, 0, 1, 1, 9, 0, 0, 0, 0, 0);
      expect_out("w9_2", 0, 0, 0, 0, 1, 0);
      go(); drive(0, 0, 1, 1, 9, 0, 0, 0, 0, 0);
      expect_out("w9_3", 0, 0, 0, 0, 1, 0);
      go(); drive(0, 0, 1, 1, 9, 0, 0, 0, 0, 0);
      expect_out("w9_full", 0, 0, 0, 0, 1, 1);
      go(); drive(0, 0, 1, 1, 9, 1, 9, 32'h00000099, 0, 0);
      expect_out("w9_full_wb", 0, 0, 0, 0, 1, 1);
      go(); drive(0, 0, 1, 1, 9, 0, 0, 0, 0, 0);
      expect_out("w9_room", 0, 0, 0, 0, 1, 0);
      go(); drive(0, 0, 1, 1, 9, 0, 0, 0, 0, 0);
      expect_out("w9_full2", 0, 0, 0, 0, 1, 1);
      for (int k = 0; k < 3; k++) begin
         go(); drive(0, 0, 0, 0, 0, 1, 9, 32'h00000099, 0, 0);
      end
      go(); drive(9, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("w9_drained", 1, 32'h00000099, 0, 0, 1, 0);

      // Same-cycle inc and dec leaves counter unchanged
      go(); drive(0, 0, 1, 1, 10, 0, 0, 0, 0, 0);
      expect_out("w10_1", 0, 0, 0, 0, 1, 0);
      go(); drive(0, 0, 1, 1, 10, 1, 10, 32'h0000000A, 0, 0);
      expect_out("w10_incdec", 0, 0, 0, 0, 1, 0);
      go(); drive(10, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("w10_still", 0, 0, 0, 0, 1, 1);
      go(); drive(0, 0, 0, 0, 0, 1, 10, 32'h0000000A, 0, 0);

      // Flush overrides same-cycle accept; writeback still lands
      go(); drive(0, 0, 1, 1, 3, 0, 0, 0, 0, 0);
      expect_out("w3", 0, 0, 0, 0, 1, 0);
      go(); drive(0, 0, 1, 1, 4, 0, 0, 0, 0, 0);
      expect_out("w4", 0, 0, 0, 0, 1, 0);
      go(); drive(3, 4, 0, 0, 0, 0, 0, 0, 0, 0);
      go(); drive(3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("pend3", 0, 0, 0, 0, 1, 1);
      go(); drive(0, 0, 1, 1, 3, 1, 4, 32'h00000044, 1, 0);
      expect_out("flush_iss3", 0, 0, 0, 0, 1, 0);
      go(); drive(3, 4, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("post_flush", 0, 0, 1, 32'h00000044, 1, 0);

      // Reset mid-operation with pending counters and a writeback
      go(); drive(0, 0, 1, 1, 12, 0, 0, 0, 0, 0);
      expect_out("w12_1", 0, 0, 0, 0, 1, 0);
      go(); drive(0, 0, 1, 1, 12, 0, 0, 0, 0, 0);
      expect_out("w12_2", 0, 0, 0, 0, 1, 0);
      go(); drive(0, 0, 1, 1, 12, 1, 5, 32'h00000055, 0, 1);
      go(); drive(5, 12, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("rst_mid", 1, 0, 1, 0, 1, 0);
      go(); drive(7, 9, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("rst_regs", 1, 0, 1, 0, 1, 0);

      // Drain the scoreboard with a bounded wait
      go(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      budget = 20;
      while (sb.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      if (sb.size() > 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL drain entries_left=%0d want=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
